// File: rtl/breakout_pixel_renderer.sv
// Breakout game logic and pixel colour generator driven by a 640x480 VGA raster.
// Game state advances once per frame; RGB is registered on every pixel strobe.
module breakout_pixel_renderer #(
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 448,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int BRICK_W      = 80,
    parameter int BRICK_H      = 16,
    parameter int BRICK_TOP    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vga_clk,
    input  logic [9:0] xPixel,
    input  logic [9:0] yPixel,
    input  logic       active_pixels,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_serve,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        LOST  = 2'd2,
        WON   = 2'd3
    } state_t;

    localparam logic [10:0] PW        = 11'(PADDLE_W);
    localparam logic [10:0] PH        = 11'(PADDLE_H);
    localparam logic [10:0] PY        = 11'(PADDLE_Y);
    localparam logic [10:0] PSPD      = 11'(PADDLE_SPEED);
    localparam logic [10:0] BS        = 11'(BALL_SIZE);
    localparam logic [10:0] BSPD      = 11'(BALL_SPEED);
    localparam logic [10:0] FIELD_TOP = 11'(BRICK_TOP);
    localparam logic [10:0] FIELD_BOT = 11'(BRICK_TOP + 4 * BRICK_H);
    localparam logic [10:0] SCR_W     = 11'd640;
    localparam logic [10:0] SCR_H     = 11'd480;
    localparam logic [10:0] PX_MAX    = 11'(640 - PADDLE_W);
    localparam logic [10:0] PX_INIT   = 11'd288;
    localparam logic [10:0] BALL_OFF  = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [10:0] BY_SERVE  = 11'(PADDLE_Y - BALL_SIZE);
    localparam logic [10:0] HALF_BALL = 11'(BALL_SIZE / 2);

    function automatic logic [2:0] brick_col(input logic [10:0] x);
        brick_col = 3'd0;
        for (int c = 1; c < 8; c++) begin
            if (x >= 11'(c * BRICK_W)) brick_col = 3'(c);
        end
    endfunction

    function automatic logic [1:0] brick_row(input logic [10:0] y);
        brick_row = 2'd0;
        for (int r = 1; r < 4; r++) begin
            if (y >= 11'(BRICK_TOP + r * BRICK_H)) brick_row = 2'(r);
        end
    endfunction

    // Grout: first column / first row of every brick cell stays unlit.
    function automatic logic on_grout(input logic [10:0] x, input logic [10:0] y);
        on_grout = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (x == 11'(c * BRICK_W)) on_grout = 1'b1;
        end
        for (int r = 0; r < 4; r++) begin
            if (y == 11'(BRICK_TOP + r * BRICK_H)) on_grout = 1'b1;
        end
    endfunction

    function automatic logic [23:0] row_colour(input logic [1:0] row);
        case (row)
            2'd0:    row_colour = 24'hFF0000;
            2'd1:    row_colour = 24'hFF8000;
            2'd2:    row_colour = 24'hFFFF00;
            2'd3:    row_colour = 24'h00FF00;
            default: row_colour = 24'h000000;
        endcase
    endfunction

    state_t      state_r, state_next_s;
    logic [1:0]  game_state_r;
    logic [10:0] px_r, bx_r, by_r;
    logic        dx_r, dy_r;             // 1 = moving right / down
    logic [31:0] bricks_r;
    logic [23:0] rgb_r;

    logic [10:0] px_next_s, bx_next_s, by_next_s;
    logic        dx_next_s, dy_next_s;
    logic [31:0] bricks_next_s;

    logic        frame_tick_s, ball_out_s;
    logic [10:0] px_moved_s, centre_x_s, centre_y_s;
    logic        wall_flip_s, top_flip_s, paddle_flip_s, brick_hit_s;
    logic [4:0]  brick_idx_s;
    logic        dx_play_s, dy_play_s;
    logic [10:0] bx_play_s, by_play_s;
    logic [31:0] bricks_play_s;

    logic [10:0] x_s, y_s;
    logic        ball_px_s, paddle_px_s, brick_px_s;
    logic [1:0]  pix_row_s;
    logic [2:0]  pix_col_s;
    logic [23:0] colour_s;

    assign frame_tick_s = vga_clk && (xPixel == 10'd0) && (yPixel == 10'd480);

    // Paddle motion and ball physics for the current frame, from pre-move positions.
    always_comb begin
        if (btn_left && !btn_right) begin
            px_moved_s = (px_r >= PSPD) ? px_r - PSPD : 11'd0;
        end else if (btn_right && !btn_left) begin
            px_moved_s = (px_r + PSPD >= PX_MAX) ? PX_MAX : px_r + PSPD;
        end else begin
            px_moved_s = px_r;
        end
        ball_out_s    = by_r >= SCR_H;
        wall_flip_s   = dx_r ? (bx_r + BS >= SCR_W - BSPD) : (bx_r <= BSPD);
        top_flip_s    = !dy_r && (by_r <= BSPD);
        paddle_flip_s = dy_r && (by_r + BS >= PY) && (by_r + BS <= PY + BSPD)
                        && (bx_r + BS - 11'd1 >= px_r) && (bx_r <= px_r + PW - 11'd1);
        centre_x_s    = bx_r + HALF_BALL;
        centre_y_s    = by_r + HALF_BALL;
        brick_idx_s   = {brick_row(centre_y_s), brick_col(centre_x_s)};
        brick_hit_s   = (centre_y_s >= FIELD_TOP) && (centre_y_s < FIELD_BOT)
                        && (centre_x_s < SCR_W) && bricks_r[brick_idx_s];
        bricks_play_s = brick_hit_s ? (bricks_r & ~(32'd1 << brick_idx_s)) : bricks_r;
        dx_play_s     = dx_r ^ wall_flip_s;
        dy_play_s     = dy_r ^ (top_flip_s | paddle_flip_s | brick_hit_s);
        bx_play_s     = dx_play_s ? bx_r + BSPD : ((bx_r >= BSPD) ? bx_r - BSPD : 11'd0);
        by_play_s     = dy_play_s ? by_r + BSPD : ((by_r >= BSPD) ? by_r - BSPD : 11'd0);
    end

    // FSM next state, evaluated only on the frame tick.
    always_comb begin
        state_next_s = state_r;
        if (frame_tick_s) begin
            case (state_r)
                SERVE:     state_next_s = btn_serve ? PLAY : SERVE;
                PLAY: begin
                    if (ball_out_s) begin
                        state_next_s = LOST;
                    end else if (bricks_play_s == 32'd0) begin
                        state_next_s = WON;
                    end else begin
                        state_next_s = PLAY;
                    end
                end
                LOST, WON: state_next_s = btn_serve ? SERVE : state_r;
                default:   state_next_s = SERVE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Game datapath next values per FSM state.
    always_comb begin
        px_next_s     = px_r;
        bx_next_s     = bx_r;
        by_next_s     = by_r;
        dx_next_s     = dx_r;
        dy_next_s     = dy_r;
        bricks_next_s = bricks_r;
        if (frame_tick_s) begin
            case (state_r)
                SERVE: begin
                    px_next_s = px_moved_s;
                    bx_next_s = px_moved_s + BALL_OFF;
                    by_next_s = BY_SERVE;
                    if (btn_serve) begin
                        dx_next_s = 1'b1;
                        dy_next_s = 1'b0;
                    end else begin
                        dx_next_s = dx_r;
                        dy_next_s = dy_r;
                    end
                end
                PLAY: begin
                    px_next_s = px_moved_s;
                    if (!ball_out_s) begin
                        bx_next_s     = bx_play_s;
                        by_next_s     = by_play_s;
                        dx_next_s     = dx_play_s;
                        dy_next_s     = dy_play_s;
                        bricks_next_s = bricks_play_s;
                    end else begin
                        bricks_next_s = bricks_r;
                    end
                end
                LOST, WON: begin
                    if (btn_serve) begin
                        px_next_s     = PX_INIT;
                        bricks_next_s = 32'hFFFF_FFFF;
                    end else begin
                        px_next_s     = px_r;
                    end
                end
                default: px_next_s = px_r;
            endcase
        end else begin
            px_next_s = px_r;
        end
    end

    // FSM state register and its output copy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= SERVE;
            game_state_r <= 2'd0;
        end else begin
            state_r      <= state_next_s;
            game_state_r <= state_next_s;
        end
    end

    // Game datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            px_r     <= PX_INIT;
            bx_r     <= PX_INIT + BALL_OFF;
            by_r     <= BY_SERVE;
            dx_r     <= 1'b1;
            dy_r     <= 1'b0;
            bricks_r <= 32'hFFFF_FFFF;
        end else begin
            px_r     <= px_next_s;
            bx_r     <= bx_next_s;
            by_r     <= by_next_s;
            dx_r     <= dx_next_s;
            dy_r     <= dy_next_s;
            bricks_r <= bricks_next_s;
        end
    end

    // Pixel colour for the current raster coordinate, first match wins.
    always_comb begin
        x_s         = {1'b0, xPixel};
        y_s         = {1'b0, yPixel};
        ball_px_s   = (x_s >= bx_r) && (x_s < bx_r + BS) && (y_s >= by_r) && (y_s < by_r + BS);
        paddle_px_s = (x_s >= px_r) && (x_s < px_r + PW) && (y_s >= PY) && (y_s < PY + PH);
        pix_row_s   = brick_row(y_s);
        pix_col_s   = brick_col(x_s);
        brick_px_s  = (y_s >= FIELD_TOP) && (y_s < FIELD_BOT) && (x_s < SCR_W)
                      && bricks_r[{pix_row_s, pix_col_s}] && !on_grout(x_s, y_s);
        if (!active_pixels) begin
            colour_s = 24'h000000;
        end else if (ball_px_s) begin
            colour_s = 24'hFFFFFF;
        end else if (paddle_px_s) begin
            colour_s = 24'h00C0FF;
        end else if (brick_px_s) begin
            colour_s = row_colour(pix_row_s);
        end else begin
            case (state_r)
                LOST:    colour_s = 24'h400000;
                WON:     colour_s = 24'h004000;
                default: colour_s = 24'h000000;
            endcase
        end
    end

    // RGB output register, advancing only on pixel strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_r <= 24'h000000;
        end else if (vga_clk) begin
            rgb_r <= colour_s;
        end else begin
            rgb_r <= rgb_r;
        end
    end

    assign VGA_R      = rgb_r[23:16];
    assign VGA_G      = rgb_r[15:8];
    assign VGA_B      = rgb_r[7:0];
    assign game_state = game_state_r;

endmodule

// File: tb/tb_breakout_pixel_renderer.sv
// Scoreboard bench for breakout_pixel_renderer: a game-level reference model
// predicts RGB and game_state for every clock; a monitor compares each cycle.
module tb_breakout_pixel_renderer;

    localparam int P_W = 64, P_Y = 448, P_H = 8, P_SPD = 4;
    localparam int B_SZ = 8, B_SPD = 2, BR_W = 80, BR_H = 16, BR_TOP = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vga_clk = 1'b0;
    logic [9:0] xPixel = 10'd0;
    logic [9:0] yPixel = 10'd0;
    logic       active_pixels = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_serve = 1'b0;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic [1:0] game_state;

    always #5 clk = ~clk;

    breakout_pixel_renderer dut (
        .clk(clk), .rst(rst), .vga_clk(vga_clk), .xPixel(xPixel), .yPixel(yPixel),
        .active_pixels(active_pixels), .btn_left(btn_left), .btn_right(btn_right),
        .btn_serve(btn_serve), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .game_state(game_state)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb_q[$];
    int total = 0;
    int bad   = 0;

    // Reference game model
    int          m_px, m_bx, m_by, m_dx, m_dy, m_state;
    logic [31:0] m_bricks;
    logic [23:0] m_rgb;
    logic [23:0] row_rgb [4] = '{24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00};

    task automatic model_reset();
        m_px = 288; m_bx = 316; m_by = 440; m_dx = 1; m_dy = -1;
        m_state = 0; m_bricks = 32'hFFFF_FFFF; m_rgb = 24'h0;
    endtask

    function automatic logic [23:0] model_pixel(input int x, input int y, input bit act);
        int row, col;
        if (!act) return 24'h000000;
        if (x >= m_bx && x < m_bx + B_SZ && y >= m_by && y < m_by + B_SZ) return 24'hFFFFFF;
        if (x >= m_px && x < m_px + P_W && y >= P_Y && y < P_Y + P_H) return 24'h00C0FF;
        if (y >= BR_TOP && y < BR_TOP + 4 * BR_H && x < 640) begin
            row = (y - BR_TOP) / BR_H;
            col = x / BR_W;
            if (m_bricks[row * 8 + col] && (x % BR_W) != 0 && ((y - BR_TOP) % BR_H) != 0)
                return row_rgb[row];
        end
        if (m_state == 2) return 24'h400000;
        if (m_state == 3) return 24'h004000;
        return 24'h000000;
    endfunction

    task automatic model_tick(input bit l, input bit r, input bit sv);
        int  opx, ndx, cx, cy, idx;
        bit  flip_y;
        opx = m_px;
        if (m_state == 0 || m_state == 1) begin
            if (l && !r) m_px = (m_px >= P_SPD) ? m_px - P_SPD : 0;
            else if (r && !l) m_px = (m_px + P_SPD > 640 - P_W) ? 640 - P_W : m_px + P_SPD;
        end
        case (m_state)
            0: begin
                m_bx = m_px + P_W / 2 - B_SZ / 2;
                m_by = P_Y - B_SZ;
                if (sv) begin m_state = 1; m_dx = 1; m_dy = -1; end
            end
            1: begin
                if (m_by >= 480) begin
                    m_state = 2;
                end else begin
                    ndx = m_dx;
                    flip_y = 0;
                    if ((m_dx < 0 && m_bx <= B_SPD) || (m_dx > 0 && m_bx + B_SZ >= 640 - B_SPD)) ndx = -m_dx;
                    if (m_dy < 0 && m_by <= B_SPD) flip_y = 1;
                    if (m_dy > 0 && m_by + B_SZ >= P_Y && m_by + B_SZ <= P_Y + B_SPD
                        && m_bx + B_SZ - 1 >= opx && m_bx <= opx + P_W - 1) flip_y = 1;
                    cx = m_bx + B_SZ / 2;
                    cy = m_by + B_SZ / 2;
                    if (cy >= BR_TOP && cy < BR_TOP + 4 * BR_H && cx < 640) begin
                        idx = ((cy - BR_TOP) / BR_H) * 8 + cx / BR_W;
                        if (m_bricks[idx]) begin m_bricks[idx] = 1'b0; flip_y = 1; end
                    end
                    m_dx = ndx;
                    if (flip_y) m_dy = -m_dy;
                    m_bx = m_bx + B_SPD * m_dx; if (m_bx < 0) m_bx = 0;
                    m_by = m_by + B_SPD * m_dy; if (m_by < 0) m_by = 0;
                    if (m_bricks == 32'd0) m_state = 3;
                end
            end
            default: if (sv) begin m_bricks = 32'hFFFF_FFFF; m_px = 288; m_state = 0; end
        endcase
    endtask

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input bit s, input int x, input int y, input bit act,
                       input bit l, input bit r, input bit sv, input bit rv,
                       input bit fen, input logic [23:0] frgb);
        exp_t        e;
        logic [23:0] exp_rgb;
        @(negedge clk);
        rst = rv; vga_clk = s; xPixel = 10'(x); yPixel = 10'(y);
        active_pixels = act; btn_left = l; btn_right = r; btn_serve = sv;
        if (!rv) begin
            model_reset();
            exp_rgb = 24'h0;
        end else if (s) begin
            m_rgb = model_pixel(x, y, act);
            exp_rgb = fen ? frgb : m_rgb;
            if (x == 0 && y == 480) model_tick(l, r, sv);
        end else begin
            exp_rgb = m_rgb;
        end
        e.rgb = exp_rgb;
        e.st  = 2'(m_state);
        sb_q.push_back(e);
    endtask

    task automatic idle();
        int x, y;
        if ($urandom_range(3) == 0) begin x = 0; y = 480; end
        else begin x = $urandom_range(799); y = $urandom_range(524); end
        cyc(1'b0, x, y, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'b1, 1'b0, 24'h0);
    endtask

    task automatic frame(input bit l, input bit r, input bit sv);
        cyc(1'b1, 0, 480, 1'b0, l, r, sv, 1'b1, 1'b0, 24'h0);
        idle();
    endtask

    task automatic probe_fixed(input int x, input int y, input logic [23:0] rgb);
        cyc(1'b1, x, y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rgb);
        idle();
    endtask

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    task automatic rand_probe();
        int x, y;
        case ($urandom_range(3))
            0: begin x = $urandom_range(799); y = $urandom_range(524); end
            1: begin x = clampc(m_bx - 2 + $urandom_range(11)); y = clampc(m_by - 2 + $urandom_range(11)); end
            2: begin x = clampc(m_px - 2 + $urandom_range(67)); y = 446 + $urandom_range(11); end
            default: begin x = $urandom_range(639); y = 62 + $urandom_range(67); end
        endcase
        cyc(1'b1, x, y, (x < 640 && y < 480), 1'($urandom_range(1)), 1'($urandom_range(1)),
            1'b0, 1'b1, 1'b0, 24'h0);
        idle();
    endtask

    // Monitor: compare DUT outputs against the scoreboard after every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if ({VGA_R, VGA_G, VGA_B} !== e.rgb) begin
                    bad++;
                    $display("FAIL rgb: got %06h want %06h at %0t", {VGA_R, VGA_G, VGA_B}, e.rgb, $time);
                end
                total++;
                if (game_state !== e.st) begin
                    bad++;
                    $display("FAIL game_state: got %0d want %0d at %0t", game_state, e.st, $time);
                end
            end
        end
    end

    initial begin
        int  target;
        bit  l_b, r_b, was_lost;
        model_reset();
        cyc(1'b1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 0, 480, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

        frame(1'b0, 1'b0, 1'b0);
        probe_fixed(320, 444, 24'hFFFFFF);
        probe_fixed(300, 450, 24'h00C0FF);
        probe_fixed(0, 0, 24'h000000);
        probe_fixed(250, 120, 24'h00FF00);
        probe_fixed(80, 64, 24'h000000);
        probe_fixed(81, 65, 24'hFF0000);
        probe_fixed(639, 127, 24'h00FF00);

        for (int i = 0; i < 80; i++) begin
            frame(1'b1, 1'b0, 1'b0);
            if (i == 71) probe_fixed(0, 450, 24'h00C0FF);
        end
        probe_fixed(63, 455, 24'h00C0FF);
        probe_fixed(64, 450, 24'h000000);
        frame(1'b1, 1'b1, 1'b0);
        probe_fixed(0, 450, 24'h00C0FF);
        probe_fixed(64, 450, 24'h000000);

        for (int i = 0; i < 72; i++) frame(1'b0, 1'b1, 1'b0);
        probe_fixed(288, 448, 24'h00C0FF);
        probe_fixed(287, 450, 24'h000000);
        probe_fixed(351, 455, 24'h00C0FF);
        probe_fixed(352, 450, 24'h000000);

        frame(1'b0, 1'b0, 1'b1);
        probe_fixed(316, 440, 24'hFFFFFF);
        frame(1'b0, 1'b0, 1'b0);
        probe_fixed(318, 438, 24'hFFFFFF);
        probe_fixed(317, 438, 24'h000000);
        probe_fixed(325, 445, 24'hFFFFFF);
        frame(1'b0, 1'b0, 1'b0);
        probe_fixed(320, 436, 24'hFFFFFF);
        probe_fixed(319, 436, 24'h000000);
        probe_fixed(328, 436, 24'h000000);

        // Steer the paddle under the ball to work through the brick field.
        for (int f = 0; f < 9000 && m_state == 1; f++) begin
            target = m_bx + B_SZ / 2 - P_W / 2;
            l_b = (m_px > target + 2);
            r_b = (m_px + 2 < target);
            frame(l_b, r_b, 1'b0);
            if (f % 16 == 0) repeat (3) rand_probe();
        end
        // Move the paddle away so the ball drops out.
        for (int f = 0; f < 3000 && m_state == 1; f++) begin
            if (m_bx + B_SZ / 2 < 320) frame(1'b0, 1'b1, 1'b0);
            else frame(1'b1, 1'b0, 1'b0);
            if (f % 32 == 0) rand_probe();
        end
        frame(1'b0, 1'b0, 1'b0);
        was_lost = (m_state == 2);
        if (m_state == 2) probe_fixed(639, 479, 24'h400000);
        else if (m_state == 3) probe_fixed(639, 479, 24'h004000);
        repeat (4) rand_probe();
        frame(1'b0, 1'b0, 1'b1);
        if (was_lost) begin
            probe_fixed(250, 120, 24'h00FF00);
            probe_fixed(288, 448, 24'h00C0FF);
            probe_fixed(639, 479, 24'h000000);
        end
        repeat (4) rand_probe();

        for (int f = 0; f < 300; f++) begin
            frame(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(15) == 0));
            repeat (4) rand_probe();
        end

        // Reset in the middle of a frame, then the power-on picture again.
        rand_probe();
        cyc(1'b1, 100, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        idle();
        frame(1'b0, 1'b0, 1'b0);
        probe_fixed(320, 444, 24'hFFFFFF);
        probe_fixed(300, 450, 24'h00C0FF);
        probe_fixed(0, 0, 24'h000000);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/breakout_pixel_renderer.md
Name: breakout_pixel_renderer

Overview:
- Sits directly downstream of the 640x480 VGA timing generator.
- Consumes its pixel strobe (vga_clk), pixel coordinates and active flag.
- Owns the Breakout game state: paddle, ball, 8x4 brick bitmap and the game FSM.
- Updates game state once per frame and produces registered 8-bit-per-channel RGB for the DE2-115 DAC.

Parameters:
- PADDLE_W, 64, paddle width in pixels.
- PADDLE_H, 8, paddle height.
- PADDLE_Y, 448, paddle top row.
- PADDLE_SPEED, 4, paddle pixels per frame.
- BALL_SIZE, 8, ball square side.
- BALL_SPEED, 2, ball pixels per frame per axis.
- BRICK_W, 80, brick cell width; 8 columns cover x 0..639.
- BRICK_H, 16, brick cell height.
- BRICK_TOP, 64, top row of brick field; 4 rows cover y 64..127.

Ports:
- clk  in  1  system clock, same clock as the timing generator.
- rst  in  1  synchronous, active-low reset.
- vga_clk  in  1  pixel strobe; state/output advance only on clk cycles where vga_clk==1.
- xPixel  in  10  current x from timing generator.
- yPixel  in  10  current y.
- active_pixels  in  1  high inside the 640x480 active area.
- btn_left  in  1  move paddle left; already synchronized and debounced; active high.
- btn_right  in  1  move paddle right; same conditioning.
- btn_serve  in  1  launch ball or restart; same conditioning.
- VGA_R  out  8  red.
- VGA_G  out  8  green.
- VGA_B  out  8  blue.
- game_state  out  2  0=SERVE, 1=PLAY, 2=LOST, 3=WON.

Behaviour:
- Reset (one clk edge with rst==0, synchronous): RGB=0, state=SERVE, px=288, ball bx=316 by=440, dx=+1, dy=-1, bricks=32'hFFFF_FFFF. Reset mid-frame takes effect on the next edge; rendering resumes with the next strobe.
- frame_tick: vga_clk==1 && xPixel==0 && yPixel==480. Exactly one per frame. All game updates occur only on frame_tick.
- Paddle, in SERVE and PLAY only:
  - left-only: px -= PADDLE_SPEED, clamp at 0.
  - right-only: px += PADDLE_SPEED, clamp at 640-PADDLE_W.
  - both or neither: no move.
- SERVE:
  - Ball tracks paddle: bx = px+PADDLE_W/2-BALL_SIZE/2, by = PADDLE_Y-BALL_SIZE, using the post-move px.
  - btn_serve on tick: go to PLAY, set dx=+, dy=-.
- PLAY: checks run on pre-move position, in this order:
  - (1) Bottom: by >= 480 -> LOST; ball frozen.
  - (2) Side walls: dx<0 && bx <= BALL_SPEED, or dx>0 && bx+BALL_SIZE >= 640-BALL_SPEED -> flip dx.
  - (3) Top: dy<0 && by <= BALL_SPEED -> flip dy.
  - (4) Paddle: dy>0 && by+BALL_SIZE in [PADDLE_Y, PADDLE_Y+BALL_SPEED] && ball x-span overlaps [px, px+PADDLE_W-1] -> flip dy.
  - (5) Brick: centre (bx+4, by+4) lies in the brick field and its cell bit is set -> clear bit, flip dy. A dy flip from (3) or (4) in the same tick is not flipped twice. At most one brick is cleared per tick.
  - Then move bx, by by ±BALL_SPEED using the updated signs. Left-wall arithmetic must never underflow below 0.
  - Bitmap becomes zero -> WON on the same tick.
- Brick bit index = row*8+col. Row 0 is the top row; col 0 is the left column.
- LOST/WON: btn_serve on tick -> bricks=all ones, px=288, state=SERVE. No other change.
- Pixel output: registered, updated only when vga_clk==1, one-strobe latency from the coordinates. Colours are 24-bit hex RRGGBB.
  - active_pixels==0 -> 000000.
  - Otherwise, first match wins:
    - ball square -> FFFFFF.
    - paddle rectangle -> 00C0FF.
    - set brick cell, excluding local x==0 and local y==0 (1-px grout) -> row colour: row0 FF0000, row1 FF8000, row2 FFFF00, row3 00FF00.
    - background: 000000 in SERVE/PLAY, 400000 in LOST, 004000 in WON.
- game_state is a registered copy of the FSM state.

Test Plan:
- Reset, then one frame with no buttons -> state SERVE; ball at (316,440); pixel (320,444) renders FFFFFF; pixel (300,450) renders 00C0FF; pixel (0,0) renders 000000.
- Hold btn_left for 80 frames -> px clamps at 0 after frame 72 with no wrap. Then btn_left and btn_right together for 1 frame -> px unchanged.
- Serve at px=288 -> after 1 tick ball (318,438); after 2 ticks (320,436). game_state==1.
- Force ball near the left wall (bx=2, dx=-) -> next tick dx=+ and bx=4, never negative.
- Ball rising into column 3, row 3 (centre (244,127)) -> bit 27 cleared and dy=+. Pixel (250,120) now renders background, and an adjacent set brick still renders 00FF00.
- Ball passes the paddle -> LOST at by>=480 with 400000 background. btn_serve -> SERVE, bricks all ones, px=288. Clearing the last brick instead -> WON, 004000 background.
